// File: rtl/pc_gen.sv
// Fetch PC generator for the five-stage pipeline: sequential issue over valid/ready,
// prioritised trap/mret/branch redirects, epoch tagging and a halt on misaligned targets.
module pc_gen #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [31:0] RESET_VEC  = 32'h8000_0000,
  parameter int unsigned INST_BYTES = 4,
  parameter int unsigned EPOCH_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trap_valid,
  input  logic [WIDTH-1:0]   trap_target,
  input  logic               mret_valid,
  input  logic [WIDTH-1:0]   mret_target,
  input  logic               br_valid,
  input  logic [WIDTH-1:0]   br_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_pc,
  output logic [EPOCH_W-1:0] out_epoch,
  output logic               out_misalign,
  output logic [31:0]        redirect_cnt
);

  localparam int unsigned      OFF_W    = $clog2(INST_BYTES);
  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(INST_BYTES);

  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               valid_q, valid_d;
  logic               misalign_q, misalign_d;
  logic               halt_q, halt_d;
  logic [31:0]        cnt_q, cnt_d;

  logic               redirect;
  logic [WIDTH-1:0]   target;
  logic               fire;

  assign redirect = trap_valid | mret_valid | br_valid;
  assign fire     = valid_q & out_ready;

  always_comb begin
    target = br_target;
    if (trap_valid) begin
      target = trap_target;
    end else if (mret_valid) begin
      target = mret_target;
    end
  end

  // valid_q=0 with halt_q=0 only occurs right after reset; issue starts on the next edge.
  always_comb begin
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    halt_d     = halt_q;
    cnt_d      = cnt_q;
    if (redirect) begin
      pc_d       = target;
      epoch_d    = epoch_q + EPOCH_W'(1);
      cnt_d      = cnt_q + 32'd1;
      valid_d    = 1'b1;
      misalign_d = |target[OFF_W-1:0];
      halt_d     = 1'b0;
    end else if (fire) begin
      if (misalign_q) begin
        valid_d = 1'b0;
        halt_d  = 1'b1;
      end else begin
        pc_d = pc_q + STEP;
      end
    end else if (!valid_q && !halt_q) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      epoch_q    <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      halt_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      halt_q     <= halt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_epoch    = epoch_q;
  assign out_misalign = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random traffic, every cycle's presented
// request predicted by a behavioural model and checked through a scoreboard queue.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid, mret_valid, br_valid, out_ready;
  logic [31:0] trap_target, mret_target, br_target;
  logic        out_valid, out_misalign;
  logic [31:0] out_pc, redirect_cnt;
  logic [1:0]  out_epoch;

  pc_gen #(.WIDTH(32), .RESET_VEC(RV), .INST_BYTES(4), .EPOCH_W(2)) dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .mret_valid(mret_valid), .mret_target(mret_target),
    .br_valid(br_valid), .br_target(br_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_epoch(out_epoch), .out_misalign(out_misalign), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit [31:0] pc;
    int        epoch;
    bit        mis;
    bit        mis_care;
    bit [31:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;        // what the DUT should be presenting now
  bit   m_halt;   // a misaligned request has been consumed; wait for a redirect
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s cycle=%0d actual=0x%08h expected=0x%08h", name, cyc, act, exp);
    else
      n_pass++;
  endtask

  // Reference rules applied at one clock edge given the inputs seen at that edge.
  task automatic model_edge(input bit r, input bit tv, input bit [31:0] tt, input bit mv,
                            input bit [31:0] mt, input bit bv, input bit [31:0] bt,
                            input bit rd);
    bit [31:0] t;
    bit fire;
    fire = m.valid && rd;
    if (r) begin
      m = '{valid: 1'b0, pc: RV, epoch: 0, mis: 1'b0, mis_care: 1'b1, cnt: 32'd0};
      m_halt = 1'b0;
    end else if (tv || mv || bv) begin
      t = tv ? tt : (mv ? mt : bt);
      m.pc = t;
      m.epoch = (m.epoch + 1) % 4;
      m.cnt = m.cnt + 1;
      m.mis = (t % 4) != 0;
      m.mis_care = 1'b1;
      m.valid = 1'b1;
      m_halt = 1'b0;
    end else if (fire) begin
      if (m.mis) begin
        m.valid = 1'b0;
        m.mis_care = 1'b0;
        m_halt = 1'b1;
      end else begin
        m.pc = m.pc + 32'd4;
      end
    end else if (!m.valid && !m_halt) begin
      m.valid = 1'b1;
      m.mis_care = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit tv, input bit [31:0] tt, input bit mv,
                      input bit [31:0] mt, input bit bv, input bit [31:0] bt, input bit rd);
    rst = r; trap_valid = tv; trap_target = tt; mret_valid = mv; mret_target = mt;
    br_valid = bv; br_target = bt; out_ready = rd;
    @(posedge clk);
    model_edge(r, tv, tt, mv, mt, bv, bt, rd);
    q.push_back(m);
    cyc++;
    #1;
  endtask

  task automatic idle(input bit rd, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, rd);
  endtask

  function automatic bit [31:0] rtgt();
    bit [31:0] t;
    t = $urandom;
    if ($urandom_range(7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  // Monitor: every cycle the DUT presents a state; compare it with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("valid", {31'd0, out_valid}, {31'd0, e.valid});
        chk("pc", out_pc, e.pc);
        chk("epoch", {30'd0, out_epoch}, e.epoch);
        chk("redirect_cnt", redirect_cnt, e.cnt);
        if (e.mis_care) chk("misalign", {31'd0, out_misalign}, {31'd0, e.mis});
        $display("cycle %0d: valid=%0d pc=%08h epoch=%0d mis=%0d cnt=%0d", cyc,
                 out_valid, out_pc, out_epoch, out_misalign, redirect_cnt);
      end
    end
  end

  initial begin
    bit r, tv, mv, bv, rd;
    m = '{valid: 1'b0, pc: RV, epoch: 0, mis: 1'b0, mis_care: 1'b1, cnt: 32'd0};
    m_halt = 1'b0;

    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    idle(1'b1, 1);
    chk("first_pc", out_pc, 32'h8000_0000);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    idle(1'b1, 2);
    chk("seq_pc", out_pc, 32'h8000_0008);
    idle(1'b0, 3);
    chk("stall_pc", out_pc, 32'h8000_0008);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    idle(1'b1, 1);
    chk("resume_pc", out_pc, 32'h8000_000C);

    step(1'b0, 1'b1, 32'h8000_1000, 1'b1, 32'h8000_2000, 1'b1, 32'h8000_3000, 1'b1);
    chk("prio_pc", out_pc, 32'h8000_1000);
    chk("prio_epoch", {30'd0, out_epoch}, 32'd1);
    chk("prio_cnt", redirect_cnt, 32'd1);

    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 32'h8000_0102, 1'b0);
    chk("mis_pc", out_pc, 32'h8000_0102);
    chk("mis_flag", {31'd0, out_misalign}, 32'd1);
    idle(1'b1, 1);
    idle(1'b1, 5);
    chk("halt_valid", {31'd0, out_valid}, 32'd0);
    chk("halt_pc", out_pc, 32'h8000_0102);
    step(1'b0, 1'b1, 32'h8000_0200, 1'b0, 0, 1'b0, 0, 1'b1);
    chk("unhalt_pc", out_pc, 32'h8000_0200);
    chk("unhalt_mis", {31'd0, out_misalign}, 32'd0);

    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    idle(1'b1, 1);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 32'h8000_4000 + 32'(i) * 32'h10, 1'b1);
    chk("wrap_epoch", {30'd0, out_epoch}, 32'd0);
    chk("wrap_cnt", redirect_cnt, 32'd4);

    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 32'h8000_5000, 1'b1);
    chk("rst_pc", out_pc, RV);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_epoch", {30'd0, out_epoch}, 32'd0);
    chk("rst_cnt", redirect_cnt, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(99) == 0);
      tv = ($urandom_range(15) == 0);
      mv = ($urandom_range(15) == 0);
      bv = ($urandom_range(7) == 0);
      rd = ($urandom_range(3) != 0);
      step(r, tv, rtgt(), mv, rtgt(), bv, rtgt(), rd);
    end
    idle(1'b1, 2);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
